// File: rtl/res_monitor_uart.sv
// Sweeps resad over RES_FIRST..RES_LAST and streams "AA:DD " records plus CR LF as 8N1 UART text.
// Latency: start bit 2 cycles after the accepting edge; start is ignored while busy.
module res_monitor_uart #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  RES_FIRST    = 8'h00,
    parameter logic [7:0]  RES_LAST     = 8'h0F
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] resad,
    input  logic [7:0] resdt,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETADR = 3'd1;
    localparam logic [2:0] S_SAMPLE = 3'd2;
    localparam logic [2:0] S_SEND   = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [7:0]    resad_q, resad_d;
    logic [7:0]    data_q, data_d;
    logic [2:0]    char_q, char_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] clk_q, clk_d;
    logic [8:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          load_en;
    logic [2:0]    load_idx;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Character indices 0..5 form a record; 6 and 7 are the CR LF line end.
    function automatic logic [7:0] char_sel(input logic [2:0] idx, input logic [7:0] a,
                                            input logic [7:0] d);
        case (idx)
            3'd0:    return hex_ascii(a[7:4]);
            3'd1:    return hex_ascii(a[3:0]);
            3'd2:    return 8'h3A;
            3'd3:    return hex_ascii(d[7:4]);
            3'd4:    return hex_ascii(d[3:0]);
            3'd5:    return 8'h20;
            3'd6:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        resad_d  = resad_q;
        data_d   = data_q;
        char_d   = char_q;
        bit_d    = bit_q;
        clk_d    = clk_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load_en  = 1'b0;
        load_idx = char_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    resad_d = RES_FIRST;
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE, S_SETADR: begin
                data_d  = resdt;
                char_d  = 3'd0;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                load_en = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (clk_q != '0) begin
                    clk_d = clk_q - 1'b1;
                end else if (bit_q != 4'd9) begin
                    txd_d   = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                    bit_d   = bit_q + 4'd1;
                    clk_d   = BIT_LAST;
                end else begin
                    // Stop bit just ended: chain the next character or leave SEND.
                    case (char_q)
                        3'd5: begin
                            if (resad_q != RES_LAST) begin
                                resad_d = resad_q + 8'd1;
                                state_d = S_SETADR;
                            end else begin
                                load_en  = 1'b1;
                                load_idx = 3'd6;
                                char_d   = 3'd6;
                            end
                        end
                        3'd7: begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            resad_d = RES_FIRST;
                            state_d = S_IDLE;
                        end
                        default: begin
                            load_en  = 1'b1;
                            load_idx = char_q + 3'd1;
                            char_d   = char_q + 3'd1;
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_en) begin
            shift_d = {1'b1, char_sel(load_idx, resad_q, data_q)};
            txd_d   = 1'b0;
            bit_d   = 4'd0;
            clk_d   = BIT_LAST;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            resad_q <= RES_FIRST;
            data_q  <= 8'h00;
            char_q  <= 3'd0;
            bit_q   <= 4'd0;
            clk_q   <= '0;
            shift_q <= 9'h000;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            resad_q <= resad_d;
            data_q  <= data_d;
            char_q  <= char_d;
            bit_q   <= bit_d;
            clk_q   <= clk_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign resad = resad_q;
    assign txd   = txd_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_res_monitor_uart.sv
// Directed bench: two monitor instances (low range and FE..FF wrap range) with a bench-side UART decoder.
module tb_res_monitor_uart;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] resad_a, resad_b;
    logic [7:0] resdt_a, resdt_b;
    logic       txd_a, txd_b, busy_a, busy_b, done_a, done_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign resdt_a = resad_a ^ 8'hA5;
    assign resdt_b = resad_b + 8'h01;

    res_monitor_uart #(.CLKS_PER_BIT(4), .RES_FIRST(8'h00), .RES_LAST(8'h01)) dut_a (
        .clock(clk), .reset(rst), .start(start_a), .resad(resad_a), .resdt(resdt_a),
        .txd(txd_a), .busy(busy_a), .done(done_a)
    );

    res_monitor_uart #(.CLKS_PER_BIT(4), .RES_FIRST(8'hFE), .RES_LAST(8'hFF)) dut_b (
        .clock(clk), .reset(rst), .start(start_b), .resad(resad_b), .resdt(resdt_b),
        .txd(txd_b), .busy(busy_b), .done(done_b)
    );

    // UART receivers, 4 clocks per bit, sampling mid-bit on the falling clock edge
    logic [7:0] rxq0[$];
    logic [7:0] rxq1[$];
    logic       rx_on[2]   = '{1'b0, 1'b0};
    logic       rx_prev[2] = '{1'b1, 1'b1};
    int         rx_t[2]    = '{0, 0};
    logic [7:0] rx_sh[2];
    logic [1:0] txv;
    assign txv = {txd_b, txd_a};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rx_on[i]) begin
                if (rx_prev[i] && !txv[i]) begin
                    rx_on[i] = 1'b1;
                    rx_t[i]  = 0;
                end
            end else begin
                rx_t[i] = rx_t[i] + 1;
                if (rx_t[i] >= 6 && rx_t[i] <= 34 && ((rx_t[i] - 6) % 4) == 0)
                    rx_sh[i] = {txv[i], rx_sh[i][7:1]};
                if (rx_t[i] == 38) begin
                    if (i == 0) rxq0.push_back(rx_sh[i]);
                    else        rxq1.push_back(rx_sh[i]);
                    rx_on[i] = 1'b0;
                end
            end
            rx_prev[i] = txv[i];
        end
    end

    logic tx_rec[0:1299];
    logic done_rec[0:1299];
    logic busy_rec[0:1299];
    logic seen00;
    int   ndone, dpos1, dpos2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // m indexes the falling edge after rising edge k+m, k being the accepting edge.
    task automatic run_sweep(input int sel, input int ncyc, input int hold, input int repulse);
        logic st;
        @(negedge clk);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        seen00 = 1'b0;
        for (int m = 0; m < ncyc; m++) begin
            @(negedge clk);
            tx_rec[m]   = (sel == 0) ? txd_a  : txd_b;
            done_rec[m] = (sel == 0) ? done_a : done_b;
            busy_rec[m] = (sel == 0) ? busy_a : busy_b;
            if (sel == 1 && resad_b == 8'h00) seen00 = 1'b1;
            st = (m + 1 < hold) || (m + 1 == repulse);
            if (sel == 0) start_a = st; else start_b = st;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        ndone = 0; dpos1 = -1; dpos2 = -1;
        for (int m = 0; m < ncyc; m++) begin
            if (done_rec[m] === 1'b1) begin
                if (ndone == 0) dpos1 = m;
                if (ndone == 1) dpos2 = m;
                ndone++;
            end
        end
    endtask

    task automatic check_line(input int sel, input int off, input string body);
        logic [7:0] c;
        for (int i = 0; i < 14; i++) begin
            if (sel == 0) c = (off + i < rxq0.size()) ? rxq0[off + i] : 8'hXX;
            else          c = (off + i < rxq1.size()) ? rxq1[off + i] : 8'hXX;
            if (i < 12)       check($sformatf("line%0d_%0d_chr%0d", sel, off, i), c, body[i]);
            else if (i == 12) check($sformatf("line%0d_%0d_cr", sel, off), c, 8'h0D);
            else              check($sformatf("line%0d_%0d_lf", sel, off), c, 8'h0A);
        end
    endtask

    initial begin
        logic [31:0] bits;
        logic        prev;
        int          trans;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_txd", txd_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_resad", resad_a, 8'h00);
        check("rst_resad_b", resad_b, 8'hFE);

        prev = txd_a; trans = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd_a !== prev) trans++;
            prev = txd_a;
        end
        check("idle_transitions", trans, 0);

        // Full sweep with bit timing
        rxq0.delete();
        run_sweep(0, 600, 1, 0);
        check("accept_busy", busy_rec[0], 1'b1);
        check("pre_start_high", {tx_rec[0], tx_rec[1]}, 2'b11);
        check("start_bit", {tx_rec[2], tx_rec[3], tx_rec[4], tx_rec[5]}, 4'b0000);
        for (int i = 0; i < 32; i++) bits[i] = tx_rec[6 + i];
        check("data_bits_0x30", bits, 32'h00FF0000);
        check("stop_bit", {tx_rec[38], tx_rec[39], tx_rec[40], tx_rec[41]}, 4'b1111);
        check("record_gap", {tx_rec[240], tx_rec[241], tx_rec[242], tx_rec[243], tx_rec[244]},
              5'b11110);
        check("done_count", ndone, 1);
        check("done_cycle", dpos1, 564);
        check("busy_before_done", busy_rec[563], 1'b1);
        check("busy_at_done", busy_rec[564], 1'b0);
        check("rx_len", rxq0.size(), 14);
        check_line(0, 0, "00:A5 01:A4 ");
        check("resad_after", resad_a, 8'h00);

        // Address range ending at FF
        rxq1.delete();
        run_sweep(1, 600, 1, 0);
        check("b_no_wrap", seen00, 1'b0);
        check("b_done_count", ndone, 1);
        check("b_done_cycle", dpos1, 564);
        check_line(1, 0, "FE:FF FF:00 ");
        check("b_resad_after", resad_b, 8'hFE);

        // start re-pulsed while busy
        rxq0.delete();
        run_sweep(0, 700, 1, 100);
        check("repulse_done_count", ndone, 1);
        check("repulse_rx_len", rxq0.size(), 14);
        check_line(0, 0, "00:A5 01:A4 ");

        // start held high
        rxq0.delete();
        run_sweep(0, 1200, 1100, 0);
        check("hold_done_count", ndone, 2);
        check("hold_done1", dpos1, 564);
        check("hold_done2", dpos2, 1129);
        check("hold_done_width", done_rec[565], 1'b0);
        check("hold_gap_busy_lo", busy_rec[564], 1'b0);
        check("hold_gap_busy_hi", busy_rec[565], 1'b1);
        check("hold_rx_len", rxq0.size(), 28);
        check_line(0, 0, "00:A5 01:A4 ");
        check_line(0, 14, "00:A5 01:A4 ");

        // Reset during the third character
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (89) @(negedge clk);
        check("mid_busy", busy_a, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_txd", txd_a, 1'b1);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_resad", resad_a, 8'h00);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        rxq0.delete();
        run_sweep(0, 600, 1, 0);
        check("post_rst_done_cycle", dpos1, 564);
        check("post_rst_rx_len", rxq0.size(), 14);
        check_line(0, 0, "00:A5 01:A4 ");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
